// File: rtl/afe_serial_cfg.sv
// Serial register writer for CCD analog front ends: snapshots a register bank on
// start and shifts address + data LSB-first on SDATA/SCK with active-low SL framing.
//
// state | meaning
// IDLE  | waiting for start; rejected requests pulse err
// SETUP | SL low, SCK low, first bit presented for CLK_DIV cycles
// SHIFT | one bit per 2*CLK_DIV cycles, SCK low then high
// HOLD  | SCK low, SL low, last bit held for CLK_DIV cycles
// GAP   | SL high between frames (CONTINUOUS=0 only), SL_GAP half-periods
// DONE  | one-cycle done pulse
module afe_serial_cfg #(
  parameter int CLK_DIV    = 8,
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 12,
  parameter int NUM_REGS   = 5,
  parameter int CONTINUOUS = 1,
  parameter int SL_GAP     = 2
) (
  input  logic                           sys_clk,
  input  logic                           rst,
  input  logic [NUM_REGS*DATA_W-1:0]     cfg_data,
  input  logic [ADDR_W-1:0]              start_addr,
  input  logic [$clog2(NUM_REGS+1)-1:0]  num_words,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic                           SDATA,
  output logic                           SCK,
  output logic                           SL
);

  localparam int NW_W    = $clog2(NUM_REGS + 1);
  localparam int REG_W   = NUM_REGS * DATA_W;
  localparam int FRAME_W = ADDR_W + REG_W;
  localparam int BC_W    = $clog2(FRAME_W + 1);
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int GAP_W   = (SL_GAP > 1) ? $clog2(SL_GAP + 1) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP, DONE} state_t;

  state_t              state, state_nxt;
  logic [DIV_W-1:0]    div_cnt;
  logic                sck_hi;
  logic [BC_W-1:0]     bits_left;
  logic [NW_W-1:0]     words_left;
  logic [GAP_W-1:0]    gap_cnt;
  logic [FRAME_W-1:0]  sh;
  logic [REG_W-1:0]    dat;
  logic [ADDR_W-1:0]   cur_addr;

  logic                div_wrap;
  logic                bit_end;
  logic                last_bit;
  logic                more_frames;
  logic                req_ok;
  logic                accept;
  logic [31:0]         req_end;
  logic [REG_W-1:0]    cfg_sel;
  logic [BC_W-1:0]     cont_len;

  // Range check in 32 bits so start_addr+num_words cannot wrap at the top of the bank.
  assign req_end     = 32'(start_addr) + 32'(num_words);
  assign req_ok      = (num_words != '0) && (req_end <= 32'(NUM_REGS));
  assign accept      = (state == IDLE) && start && req_ok;
  assign cfg_sel     = cfg_data >> (32'(start_addr) * DATA_W);
  assign cont_len    = BC_W'(ADDR_W) + BC_W'(num_words) * BC_W'(DATA_W);
  assign div_wrap    = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign bit_end     = (state == SHIFT) && div_wrap && sck_hi;
  assign last_bit    = (bits_left == BC_W'(1));
  assign more_frames = (CONTINUOUS == 0) && (words_left > NW_W'(1));

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    SL        = 1'b1;
    SCK       = 1'b0;
    SDATA     = 1'b1;
    case (state)
      IDLE: begin
        if (accept) state_nxt = SETUP;
      end
      SETUP: begin
        busy  = 1'b1;
        SL    = 1'b0;
        SDATA = sh[0];
        if (div_wrap) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy  = 1'b1;
        SL    = 1'b0;
        SCK   = sck_hi;
        SDATA = sh[0];
        if (bit_end && last_bit) state_nxt = HOLD;
      end
      HOLD: begin
        busy  = 1'b1;
        SL    = 1'b0;
        SDATA = sh[0];
        if (div_wrap) state_nxt = more_frames ? GAP : DONE;
      end
      GAP: begin
        busy = 1'b1;
        if (div_wrap && gap_cnt == GAP_W'(1)) state_nxt = SETUP;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      sck_hi     <= 1'b0;
      bits_left  <= '0;
      words_left <= '0;
      gap_cnt    <= '0;
      sh         <= '0;
      dat        <= '0;
      cur_addr   <= '0;
      err        <= 1'b0;
    end else begin
      err <= (state == IDLE) && start && !req_ok;

      if (state == IDLE || state_nxt != state || div_wrap) div_cnt <= '0;
      else                                                 div_cnt <= div_cnt + DIV_W'(1);

      // Leaving SHIFT always happens at the end of a high phase, so sck_hi lands at 0.
      if (state == SHIFT) sck_hi <= div_wrap ? ~sck_hi : sck_hi;
      else                sck_hi <= 1'b0;

      if (accept) begin
        words_left <= num_words;
        cur_addr   <= start_addr + ADDR_W'(1);
        if (CONTINUOUS != 0) begin
          sh        <= {cfg_sel, start_addr};
          bits_left <= cont_len;
        end else begin
          sh        <= FRAME_W'({cfg_sel[DATA_W-1:0], start_addr});
          dat       <= cfg_sel >> DATA_W;
          bits_left <= BC_W'(ADDR_W + DATA_W);
        end
      end else if (bit_end && !last_bit) begin
        sh        <= sh >> 1;
        bits_left <= bits_left - BC_W'(1);
      end else if (state == HOLD && div_wrap && more_frames) begin
        words_left <= words_left - NW_W'(1);
        gap_cnt    <= GAP_W'(SL_GAP);
      end else if (state == GAP && div_wrap) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
        if (gap_cnt == GAP_W'(1)) begin
          sh        <= FRAME_W'({dat[DATA_W-1:0], cur_addr});
          dat       <= dat >> DATA_W;
          cur_addr  <= cur_addr + ADDR_W'(1);
          bits_left <= BC_W'(ADDR_W + DATA_W);
        end
      end
    end
  end

endmodule

// File: tb/tb_afe_serial_cfg.sv
// Bench for afe_serial_cfg: three parameterisations checked every cycle against a
// timeline model of the serial frames, plus directed checks with literal expectations.
module tb_afe_serial_cfg;

  localparam int CD   [3] = '{8, 8, 2};
  localparam int DW   [3] = '{12, 12, 16};
  localparam int NR   [3] = '{5, 5, 8};
  localparam bit CONT [3] = '{1'b1, 1'b0, 1'b1};
  localparam int GAPH = 2;
  localparam int TMO  = 6000;

  logic sys_clk = 1'b0;
  logic rst;
  always #5 sys_clk = ~sys_clk;

  int   cfg_w [3][8];
  int   sai [3];
  int   nwi [3];
  logic st [3];
  logic [59:0]  cfg0, cfg1;
  logic [127:0] cfg2;
  logic [2:0]   sa0, sa1, sa2, nw0, nw1;
  logic [3:0]   nw2;
  logic sl [3], sck [3], sd [3], busy [3], done [3], err [3];

  always_comb begin
    for (int k = 0; k < 5; k++) begin
      cfg0[k*12 +: 12] = cfg_w[0][k][11:0];
      cfg1[k*12 +: 12] = cfg_w[1][k][11:0];
    end
    for (int k = 0; k < 8; k++) cfg2[k*16 +: 16] = cfg_w[2][k][15:0];
  end

  assign sa0 = sai[0][2:0];
  assign sa1 = sai[1][2:0];
  assign sa2 = sai[2][2:0];
  assign nw0 = nwi[0][2:0];
  assign nw1 = nwi[1][2:0];
  assign nw2 = nwi[2][3:0];

  afe_serial_cfg #(.CLK_DIV(8), .ADDR_W(3), .DATA_W(12), .NUM_REGS(5), .CONTINUOUS(1), .SL_GAP(2)) u0 (
    .sys_clk(sys_clk), .rst(rst), .cfg_data(cfg0), .start_addr(sa0), .num_words(nw0), .start(st[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0]), .SDATA(sd[0]), .SCK(sck[0]), .SL(sl[0]));

  afe_serial_cfg #(.CLK_DIV(8), .ADDR_W(3), .DATA_W(12), .NUM_REGS(5), .CONTINUOUS(0), .SL_GAP(2)) u1 (
    .sys_clk(sys_clk), .rst(rst), .cfg_data(cfg1), .start_addr(sa1), .num_words(nw1), .start(st[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1]), .SDATA(sd[1]), .SCK(sck[1]), .SL(sl[1]));

  afe_serial_cfg #(.CLK_DIV(2), .ADDR_W(3), .DATA_W(16), .NUM_REGS(8), .CONTINUOUS(1), .SL_GAP(2)) u2 (
    .sys_clk(sys_clk), .rst(rst), .cfg_data(cfg2), .start_addr(sa2), .num_words(nw2), .start(st[2]),
    .busy(busy[2]), .done(done[2]), .err(err[2]), .SDATA(sd[2]), .SCK(sck[2]), .SL(sl[2]));

  // Model: the serial bit list of the accepted request plus a cycle offset into its timeline.
  bit act [3];
  int off [3];
  int flen [3];
  int nfr [3];
  bit errx [3];
  bit bits_m [3][256];
  int checks = 0;
  int errors = 0;

  function automatic int total_of(int i);
    return nfr[i] * CD[i] * (2 * flen[i] + 2) + (nfr[i] - 1) * GAPH * CD[i];
  endfunction

  function automatic void load_model(int i);
    int p;
    p = 0;
    nfr[i]  = CONT[i] ? 1 : nwi[i];
    flen[i] = CONT[i] ? 3 + nwi[i] * DW[i] : 3 + DW[i];
    for (int w = 0; w < nwi[i]; w++) begin
      if (!CONT[i] || w == 0)
        for (int b = 0; b < 3; b++) begin
          bits_m[i][p] = (((sai[i] + w) >> b) & 1) != 0;
          p++;
        end
      for (int b = 0; b < DW[i]; b++) begin
        bits_m[i][p] = ((cfg_w[i][sai[i] + w] >> b) & 1) != 0;
        p++;
      end
    end
  endfunction

  // Expected {SL, SCK, SDATA, busy, done} for the current offset.
  function automatic logic [4:0] model_at(int i);
    int fd, per, f, o, b;
    logic l_sl, l_sck, l_sd, l_busy, l_done;
    l_sl = 1'b1; l_sck = 1'b0; l_sd = 1'b1; l_busy = 1'b0; l_done = 1'b0;
    if (act[i]) begin
      fd  = CD[i] * (2 * flen[i] + 2);
      per = fd + GAPH * CD[i];
      if (off[i] == total_of(i)) l_done = 1'b1;
      else begin
        l_busy = 1'b1;
        f = off[i] / per;
        o = off[i] % per;
        if (o < fd) begin
          l_sl = 1'b0;
          if (o < CD[i]) b = 0;
          else if (o < CD[i] * (2 * flen[i] + 1)) begin
            b     = (o - CD[i]) / (2 * CD[i]);
            l_sck = ((o - CD[i]) % (2 * CD[i])) >= CD[i];
          end else b = flen[i] - 1;
          l_sd = bits_m[i][f * flen[i] + b];
        end
      end
    end
    return {l_sl, l_sck, l_sd, l_busy, l_done};
  endfunction

  always @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        act[i]  = 1'b0;
        errx[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        bit was;
        was = act[i];
        if (act[i]) begin
          off[i]++;
          if (off[i] > total_of(i)) act[i] = 1'b0;
        end
        errx[i] = 1'b0;
        if (!was && st[i]) begin
          if (nwi[i] != 0 && sai[i] + nwi[i] <= NR[i]) begin
            load_model(i);
            act[i] = 1'b1;
            off[i] = 0;
          end else errx[i] = 1'b1;
        end
      end
    end
  end

  int rc [3], slow [3], gapc [3], dc [3], ec [3], bc [3], rgap [3], lastr [3];
  logic [255:0] capv [3];
  logic psck [3];
  int cyc = 0;
  bit run_chk = 1'b0;

  always @(negedge sys_clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      logic [5:0] got, exp;
      if (sck[i] && !psck[i]) begin
        if (rc[i] < 256) capv[i][rc[i]] = sd[i];
        rc[i]++;
        rgap[i]  = cyc - lastr[i];
        lastr[i] = cyc;
      end
      psck[i] = sck[i];
      if (!sl[i]) slow[i]++;
      if (sl[i] && busy[i]) gapc[i]++;
      if (done[i]) dc[i]++;
      if (err[i]) ec[i]++;
      if (busy[i]) bc[i]++;
      if (run_chk && !rst) begin
        got = {sl[i], sck[i], sd[i], busy[i], done[i], err[i]};
        exp = {model_at(i), errx[i]};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL cycle_cmp inst %0d cycle %0d {SL,SCK,SDATA,busy,done,err} actual %b required %b",
                   i, cyc, got, exp);
        end
      end
    end
  end

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, got, exp);
    end
  endtask

  task automatic chk_v(string nm, logic [255:0] got, logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", nm, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge sys_clk);
      #2;
    end
  endtask

  task automatic clr_mon(int i);
    rc[i] = 0; slow[i] = 0; gapc[i] = 0; dc[i] = 0; ec[i] = 0; bc[i] = 0; rgap[i] = 0;
    lastr[i] = cyc;
    capv[i] = '0;
  endtask

  task automatic do_start(int i, int a, int n);
    sai[i] = a;
    nwi[i] = n;
    st[i]  = 1'b1;
    tick(1);
    st[i]  = 1'b0;
  endtask

  task automatic wait_idle(int i);
    int n;
    n = 0;
    while ((act[i] || busy[i]) && n < TMO) begin
      tick(1);
      n++;
    end
    if (n >= TMO) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout inst %0d", i);
    end
  endtask

  task automatic wait_rc(int i, int target);
    int n;
    n = 0;
    while (rc[i] < target && n < TMO) begin
      tick(1);
      n++;
    end
    if (n >= TMO) begin
      checks++;
      errors++;
      $display("FAIL sck_edge_timeout inst %0d", i);
    end
  endtask

  function automatic logic [255:0] pack_cont(int a, int n, int dw, int w [8]);
    logic [255:0] v;
    int p;
    v = '0;
    p = 0;
    for (int b = 0; b < 3; b++) begin
      v[p] = ((a >> b) & 1) != 0;
      p++;
    end
    for (int k = 0; k < n; k++)
      for (int b = 0; b < dw; b++) begin
        v[p] = ((w[a + k] >> b) & 1) != 0;
        p++;
      end
    return v;
  endfunction

  task automatic rand_words(int i);
    for (int k = 0; k < NR[i]; k++) cfg_w[i][k] = int'($urandom_range(0, (1 << DW[i]) - 1));
  endtask

  int snap [8];
  logic [255:0] ev;

  initial begin
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0; sai[i] = 0; nwi[i] = 0; psck[i] = 1'b0;
    end
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++)
      chk("reset_outputs", int'({sl[i], sck[i], sd[i], busy[i], done[i], err[i]}), 6'b101000);
    @(posedge sys_clk);
    #2 rst = 1'b0;
    tick(2);
    run_chk = 1'b1;

    // Defaults, all five registers in one continuous frame.
    cfg_w[0][0] = 'h001; cfg_w[0][1] = 'h002; cfg_w[0][2] = 'h080; cfg_w[0][3] = 'h3FF; cfg_w[0][4] = 'h838;
    clr_mon(0);
    do_start(0, 0, 5);
    wait_idle(0);
    chk("full_sck_rises", rc[0], 63);
    chk("full_sl_low_cycles", slow[0], 1024);
    chk("full_done_pulses", dc[0], 1);
    chk("full_busy_cycles", bc[0], 1024);
    ev = '0;
    ev[62:0] = {12'h838, 12'h3FF, 12'h080, 12'h002, 12'h001, 3'b000};
    chk_v("full_bits", capv[0], ev);

    // One frame per word, registers 3 and 4.
    rand_words(1);
    clr_mon(1);
    do_start(1, 3, 2);
    wait_idle(1);
    chk("perword_sck_rises", rc[1], 30);
    chk("perword_gap_cycles", gapc[1], 16);
    chk("perword_sl_low_cycles", slow[1], 512);
    chk("perword_done_pulses", dc[1], 1);
    ev = '0;
    ev[29:0] = {cfg_w[1][4][11:0], 3'd4, cfg_w[1][3][11:0], 3'd3};
    chk_v("perword_bits", capv[1], ev);

    // Rejected requests.
    clr_mon(0);
    do_start(0, 4, 2);
    tick(3);
    chk("illegal_range_err", ec[0], 1);
    chk("illegal_range_sck", rc[0], 0);
    chk("illegal_range_busy", bc[0], 0);
    chk("illegal_range_sl", slow[0], 0);
    clr_mon(0);
    do_start(0, 1, 0);
    tick(3);
    chk("illegal_zero_err", ec[0], 1);
    chk("illegal_zero_busy", bc[0], 0);
    clr_mon(2);
    do_start(2, 7, 2);
    tick(3);
    chk("illegal_wide_err", ec[2], 1);

    // Second start and cfg_data change mid-frame.
    rand_words(0);
    for (int k = 0; k < 8; k++) snap[k] = cfg_w[0][k];
    clr_mon(0);
    do_start(0, 0, 5);
    wait_rc(0, 20);
    rand_words(0);
    do_start(0, 1, 1);
    wait_idle(0);
    chk("midstart_err", ec[0], 0);
    chk("midstart_done", dc[0], 1);
    chk("midstart_sck_rises", rc[0], 63);
    chk_v("midstart_bits", capv[0], pack_cont(0, 5, 12, snap));

    // Asynchronous reset mid-frame.
    for (int k = 0; k < 8; k++) snap[k] = cfg_w[0][k];
    clr_mon(0);
    do_start(0, 0, 5);
    wait_rc(0, 30);
    rst = 1'b1;
    #1;
    chk("async_rst_sl", int'(sl[0]), 1);
    chk("async_rst_sck", int'(sck[0]), 0);
    chk("async_rst_sdata", int'(sd[0]), 1);
    chk("async_rst_busy", int'(busy[0]), 0);
    tick(2);
    rst = 1'b0;
    tick(3);
    chk("async_rst_no_done", dc[0], 0);
    clr_mon(0);
    do_start(0, 0, 5);
    wait_idle(0);
    chk("after_rst_sck_rises", rc[0], 63);
    chk("after_rst_done", dc[0], 1);
    chk_v("after_rst_bits", capv[0], pack_cont(0, 5, 12, snap));

    // Fast divider, wide bank.
    rand_words(2);
    for (int k = 0; k < 8; k++) snap[k] = cfg_w[2][k];
    clr_mon(2);
    do_start(2, 0, 8);
    wait_idle(2);
    chk("wide_sck_rises", rc[2], 131);
    chk("wide_sck_period", rgap[2], 4);
    chk("wide_sl_low_cycles", slow[2], 528);
    chk("wide_done", dc[2], 1);
    chk_v("wide_bits", capv[2], pack_cont(0, 8, 16, snap));

    // Random requests on all three instances; the per-cycle compare does the work.
    for (int r = 0; r < 16; r++) begin
      int i, a, n;
      bit legal;
      i = int'($urandom_range(0, 2));
      a = int'($urandom_range(0, 7));
      n = int'($urandom_range(0, NR[i]));
      legal = (n != 0) && (a + n <= NR[i]);
      rand_words(i);
      clr_mon(i);
      do_start(i, a, n);
      wait_idle(i);
      tick(2);
      chk("rand_done", dc[i], legal ? 1 : 0);
      chk("rand_err", ec[i], legal ? 0 : 1);
    end

    tick(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
